// File: rtl/led_disp_pkg.sv
// rtl/led_disp_pkg.sv - shared sizes and BCD digit type for the LED display path
package led_disp_pkg;

   localparam int TIME_W_DEF = 27;
   localparam int DIGITS_DEF = 4;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/tick_bcd_counter_if.sv
// rtl/tick_bcd_counter_if.sv - switch-mode link from mode selector to tick counter
// Optional dir signal present only when TICK_DIR_EN is defined.
interface tick_bcd_counter_if
   import led_disp_pkg::*;
#(
   parameter int TIME_W = TIME_W_DEF
) ();

   logic [TIME_W-1:0] time_value;
   logic              allow_count;
   logic              clear;
`ifdef TICK_DIR_EN
   logic              dir;
`endif

   modport master (
      output time_value,
      output allow_count,
      output clear
`ifdef TICK_DIR_EN
      , output dir
`endif
   );

   modport slave (
      input time_value,
      input allow_count,
      input clear
`ifdef TICK_DIR_EN
      , input dir
`endif
   );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit of the ripple chain with carry/borrow out
// Down-count (borrow) logic built only when TICK_DIR_EN is defined.
module bcd_digit
   import led_disp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       en,
   input  logic       carry_in,
`ifdef TICK_DIR_EN
   input  logic       dir,
`endif
   output bcd_digit_t digit,
   output logic       carry_out
);

   logic at_limit;

`ifdef TICK_DIR_EN
   assign at_limit = dir ? (digit == BCD_MIN) : (digit == BCD_MAX);
`else
   assign at_limit = (digit == BCD_MAX);
`endif

   // Carry ripples combinationally so every digit settles on the same stepping edge.
   assign carry_out = carry_in && at_limit;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         digit <= BCD_MIN;
      end else if (en && carry_in) begin
`ifdef TICK_DIR_EN
         if (dir)
            digit <= at_limit ? BCD_MAX : digit - 4'd1;
         else
            digit <= at_limit ? BCD_MIN : digit + 4'd1;
`else
         digit <= at_limit ? BCD_MIN : digit + 4'd1;
`endif
      end
   end

endmodule

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - period prescaler producing tick, driving a BCD count
// TICK_DIR_EN adds the dir input for down-counting.
module tick_bcd_counter
   import led_disp_pkg::*;
#(
   parameter int TIME_W = TIME_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tick_bcd_counter_if.slave     sw,
   output logic                  tick,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  wrap
);

   logic [TIME_W-1:0] cnt;
   logic [DIGITS:0]   carry;
   logic              period_done;
   logic              step;

   // >= rather than == so a lowered period takes effect on the next running edge.
   assign period_done = (cnt >= sw.time_value);
   assign step        = sw.allow_count && !sw.clear && period_done;
   assign carry[0]    = 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n || sw.clear) begin
         cnt  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else if (sw.allow_count) begin
         if (period_done) begin
            cnt  <= '0;
            tick <= 1'b1;
            wrap <= carry[DIGITS];
         end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
            wrap <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (sw.clear),
         .en        (step),
         .carry_in  (carry[i]),
`ifdef TICK_DIR_EN
         .dir       (sw.dir),
`endif
         .digit     (bcd[4*i +: 4]),
         .carry_out (carry[i+1])
      );
   end

endmodule

// File: doc/tick_bcd_counter.md
# tick_bcd_counter

Consumer side of the switch-mode interface: accepts the period word `time_value` and enable `allow_count` from the mode selector. It divides `clk` by that period into a one-cycle `tick`, and advances a multi-digit BCD count on each tick. The count drives the LED display digit mux downstream.

## Interface
Parameters:
- `TIME_W`, 27, width of `time_value` and of the internal prescaler
- `DIGITS`, 4, number of BCD digits in the count

Ports:
- `clk` in 1: single system clock; all logic on rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `time_value` in TIME_W: tick period minus one, in `clk` cycles; sampled every cycle
- `allow_count` in 1: 1 = run prescaler and count; 0 = pause (hold state)
- `clear` in 1: synchronous clear of prescaler and count
- `dir` in 1: 0 = count up, 1 = count down; present only with `TICK_DIR_EN`
- `tick` out 1: registered one-cycle pulse at each period boundary
- `bcd` out 4*DIGITS: count, digit 0 in bits [3:0], each digit 0..9
- `wrap` out 1: registered one-cycle pulse when the count rolls over

## Operation
Reset (`rst_n`=0 at edge):
- prescaler `cnt`=0, `bcd`=0, `tick`=0, `wrap`=0

Priority per edge is `rst_n` > `clear` > `allow_count`.
- `clear`=1: same as reset; ignores `allow_count`.

Run (`allow_count`=1):
- If `cnt` >= `time_value`: `cnt`<=0, `tick`<=1, count steps once.
- Else: `cnt`<=`cnt`+1, `tick`<=0.

Pause (`allow_count`=0):
- `cnt` and `bcd` hold; `tick`<=0 and `wrap`<=0.
- Resuming continues the partial period; the prescaler is not restarted.

Count step, up:
- Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
- All digits at 9 → all 0, with `wrap`<=1 on the same edge as `tick`.

Arithmetic and edge cases:
- `cnt` is unsigned TIME_W wide and never exceeds max(`time_value`) previously seen.
- `time_value` uses a >= compare, so no overflow is possible.
- `time_value` lowered below current `cnt` → tick on the next running edge, then the new period applies.
- `time_value`=0 → `tick` high every running cycle.

## Timing
- Period is `time_value`+1 running cycles.
- From reset with N = `time_value` held and `allow_count`=1: `tick` is first high after edge N+1, then every N+1 edges.
- `bcd` and `wrap` update on the same edge that raises `tick`; zero extra latency.
- `tick` and `wrap` are never high for two consecutive cycles unless `time_value`=0.
- A mid-operation `rst_n` or `clear` takes effect on that edge and suppresses any tick due on it.
- All outputs come directly from registers.

## Configuration
Macro `TICK_DIR_EN`:
- Defined: port `dir` exists. With `dir`=1 the count step decrements: a digit at 0 goes to 9 and borrows from the next digit. All-0 → all-9, with `wrap`=1. `dir` is sampled on the stepping edge.
- Undefined: no `dir` port; up-count only; down-borrow logic is absent.

## Structure
- Shared package `led_disp_pkg`:
  - `TIME_W` and `DIGITS` defaults
  - BCD digit typedef (4-bit)
  - constants `BCD_MAX`=9 and `BCD_MIN`=0
- Sub-module `bcd_digit`: one digit register with inputs `en`, `carry_in`, `dir` and output `carry_out`, plus a synchronous clear.
  - Instantiated DIGITS times in a ripple chain.
  - Digit 0 `en` = step.
- Prescaler and the pause/clear logic live in the top.

## Test plan
- `time_value`=4, `allow_count`=1 from reset → `tick` high after edges 5, 10, 15; `bcd`=0x0001, 0x0002, 0x0003 on those edges.
- `time_value`=0, run 10 cycles from `bcd`=0x0009 → `bcd` goes to 0x0010 after the first edge, then 0x0019 at edge 10; `tick` continuously high.
- Preload to 9999 via `time_value`=0 run, then one more tick → `bcd`=0x0000 and `wrap`=1 for exactly one cycle.
- `time_value`=9, drop `allow_count` at `cnt`=6 for 20 cycles, then resume → next `tick` 4 running edges after resume; `bcd` unchanged during pause.
- `time_value`=100 with `cnt`≈60, switch to 10 → `tick` on the next edge, then every 11 cycles. Separately, `clear`=1 together with `allow_count`=1 → all outputs 0 on that edge.
- (`TICK_DIR_EN`) `dir`=1 from `bcd`=0x0000, `time_value`=0 → 0x9999 with `wrap`=1, then 0x9998.
